// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Shares one single-port, fixed-latency memory between the instruction-fetch
// port (IF) and the data port (D) of a 5-stage RV32 pipeline. Requests are
// sampled only while idle. Each access then runs through issue, wait and done.
// The done cycle returns the read data together with a one-cycle done pulse.
//
// Build option:
//   MEM_ARB_RR_EN  defined   -> round-robin between the two ports on a tie
//                  undefined -> fixed priority; the data port wins a tie
//
// Parameters:
//   ADDR_W       address width of both ports and of the memory
//   DATA_W       data width
//   MEM_LATENCY  cycles from the mem_en cycle to valid mem_rdata (1..15)
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   if_req, if_addr     fetch request, held until if_done
//   if_rdata, if_done   fetched word and its one-cycle completion pulse
//   if_stall            if_req & ~if_done
//   d_req, d_we,        data request, store flag, address and store data,
//   d_addr, d_wdata     held until d_done
//   d_rdata, d_done     load data and its one-cycle completion pulse
//   d_stall             d_req & ~d_done
//   mem_en, mem_we,     memory strobe (one cycle per access), write enable,
//   mem_addr, mem_wdata address and write data, all registered
//   mem_rdata           memory read data, valid MEM_LATENCY cycles after mem_en
module mem_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_stall,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } state_e;

    typedef enum logic {
        GntIf = 1'b0,
        GntD  = 1'b1
    } gnt_e;

    localparam logic [3:0] CntLoad = 4'(MEM_LATENCY - 1);

    state_e     state;
    gnt_e       gnt;
    logic [3:0] cnt;
    logic       pick_d;

`ifdef MEM_ARB_RR_EN
    // gnt doubles as the round-robin pointer: it always holds the last granted
    // port, is updated on every grant and resets to D. On a tie the other port wins.
    assign pick_d = d_req & (~if_req | (gnt == GntIf));
`else
    // The data port wins a tie: its instruction is older than the one being fetched.
    assign pick_d = d_req;
`endif

    assign if_stall = if_req & ~if_done;
    assign d_stall  = d_req & ~d_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            gnt       <= GntD;
            cnt       <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
        end else begin
            // Strobes and done pulses last one cycle unless re-asserted below.
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            if_done <= 1'b0;
            d_done  <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (if_req || d_req) begin
                        state  <= StIssue;
                        mem_en <= 1'b1;
                        if (pick_d) begin
                            gnt       <= GntD;
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end else begin
                            // Fetches never write; mem_wdata keeps its last value.
                            gnt      <= GntIf;
                            mem_addr <= if_addr;
                        end
                    end
                end

                StIssue: begin
                    cnt   <= CntLoad;
                    state <= StWait;
                end

                StWait: begin
                    // cnt == 0 marks the cycle in which mem_rdata is valid.
                    if (cnt == 4'd0) begin
                        state <= StDone;
                        if (gnt == GntIf) begin
                            if_rdata <= mem_rdata;
                            if_done  <= 1'b1;
                        end else begin
                            d_rdata <= mem_rdata;
                            d_done  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                StDone: begin
                    state <= StIdle;
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned LAT = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          if_stall;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          d_stall;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .MEM_LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .if_stall  (if_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .d_stall   (d_stall),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // ---------------- memory environment (fixed latency, 256 words) ----------
    function automatic logic [31:0] init_word(input int i);
        if (i == 0) return 32'h0000_0013;
        return (32'h9E37_79B1 * 32'(i)) ^ 32'h0BAD_F00D;
    endfunction

    logic        mem_init;
    logic [31:0] mem_arr [256];
    logic [31:0] rpipe [16];

    // Data is only meaningful on the valid cycle; other cycles carry noise.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(i);
        end else if (mem_en && mem_we) begin
            mem_arr[mem_addr[9:2]] <= mem_wdata;
        end
        rpipe[0] <= (mem_en && !mem_we) ? mem_arr[mem_addr[9:2]] : $urandom;
        for (int i = 1; i < 16; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata = rpipe[LAT-1];

    // ---------------- requesters ----------------------------------------------
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t if_q[$];
    txn_t d_q[$];
    txn_t if_cur, d_cur;
    bit   if_act, d_act;

    // ---------------- reference model (transaction schedule) -----------------
    logic [31:0] ref_mem [256];
    int          cyc;
    bit          busy;
    bit          m_port_d;
    int          m_issue, m_done, idle_from;
    txn_t        m_txn;
    logic [31:0] m_rexp;
    logic [31:0] e_mem_addr, e_mem_wdata, e_if_rdata, e_d_rdata;
    bit          e_d_known;
    bit          last_d;
    bit          chk_en;
    bit          exp_ifd, exp_dd, exp_en;

    int n_total = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [31:0] raddr();
        return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    endfunction

    // One clock cycle: check outputs mid-cycle, advance the model, step the clock,
    // then let the requesters react and drive the next cycle's inputs.
    task automatic cycle();
        bit pick_d;
        @(negedge clk);
        exp_en  = busy && (cyc == m_issue);
        exp_ifd = busy && (cyc == m_done) && !m_port_d;
        exp_dd  = busy && (cyc == m_done) && m_port_d;
        if (chk_en) begin
            chk("mem_en",    64'(mem_en),    64'(exp_en));
            chk("mem_we",    64'(mem_we),    64'(exp_en && m_txn.we));
            chk("mem_addr",  64'(mem_addr),  64'(e_mem_addr));
            chk("mem_wdata", 64'(mem_wdata), 64'(e_mem_wdata));
            chk("if_done",   64'(if_done),   64'(exp_ifd));
            chk("d_done",    64'(d_done),    64'(exp_dd));
            chk("if_stall",  64'(if_stall),  64'(if_req && !exp_ifd));
            chk("d_stall",   64'(d_stall),   64'(d_req && !exp_dd));
            chk("if_rdata",  64'(if_rdata),  64'(e_if_rdata));
            if (e_d_known) chk("d_rdata", 64'(d_rdata), 64'(e_d_rdata));
        end

        if (reset) begin
            busy        = 1'b0;
            idle_from   = cyc + 1;
            e_mem_addr  = '0;
            e_mem_wdata = '0;
            e_if_rdata  = '0;
            e_d_rdata   = '0;
            e_d_known   = 1'b1;
            last_d      = 1'b1;
            chk_en      = 1'b1;
        end else begin
            if (busy && cyc == m_done) begin
                busy      = 1'b0;
                idle_from = cyc + 1;
            end
            if (busy && cyc == m_done - 1) begin
                if (!m_port_d) e_if_rdata = m_rexp;
                else if (m_txn.we) e_d_known = 1'b0;
                else begin
                    e_d_rdata = m_rexp;
                    e_d_known = 1'b1;
                end
            end
            if (!busy && cyc >= idle_from && (if_req || d_req)) begin
`ifdef MEM_ARB_RR_EN
                pick_d = d_req && (!if_req || !last_d);
`else
                pick_d = d_req;
`endif
                last_d   = pick_d;
                m_port_d = pick_d;
                m_txn    = pick_d ? d_cur : '{we: 1'b0, addr: if_cur.addr, wdata: 32'd0};
                if (pick_d) e_mem_wdata = d_cur.wdata;
                e_mem_addr = m_txn.addr;
                m_rexp     = ref_mem[m_txn.addr[9:2]];
                if (m_txn.we) ref_mem[m_txn.addr[9:2]] = m_txn.wdata;
                m_issue = cyc + 1;
                m_done  = cyc + 2 + LAT;
                busy    = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        cyc++;
        if (exp_ifd) if_act = 1'b0;
        if (exp_dd)  d_act  = 1'b0;
        if (!if_act && if_q.size() > 0) begin
            if_cur = if_q.pop_front();
            if_act = 1'b1;
        end
        if (!d_act && d_q.size() > 0) begin
            d_cur = d_q.pop_front();
            d_act = 1'b1;
        end
        if_req  = if_act;
        if_addr = if_act ? if_cur.addr : $urandom;
        d_req   = d_act;
        d_we    = d_act ? d_cur.we : 1'($urandom);
        d_addr  = d_act ? d_cur.addr : $urandom;
        d_wdata = d_act ? d_cur.wdata : $urandom;
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 300; n++) begin
            if (!if_act && !d_act && !busy && if_q.size() == 0 && d_q.size() == 0) break;
            cycle();
        end
        chk(tag, 64'({if_act, d_act, busy}), 64'd0);
    endtask

    initial begin
        reset    = 1'b1;
        mem_init = 1'b1;
        if_req   = 1'b0;
        if_addr  = '0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_addr   = '0;
        d_wdata  = '0;
        if_act   = 1'b0;
        d_act    = 1'b0;
        busy     = 1'b0;
        chk_en   = 1'b0;
        cyc      = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

        @(posedge clk);
        #1;
        cycle();
        cycle();
        reset    = 1'b0;
        mem_init = 1'b0;
        cycle();

        // Lone fetch of the word at 0x0.
        if_q.push_back('{we: 1'b0, addr: 32'h0, wdata: 32'h0});
        drain("drain_fetch");
        chk("fetch0_word", 64'(if_rdata), 64'h13);

        // Store then load the same address.
        d_q.push_back('{we: 1'b1, addr: 32'h40, wdata: 32'hDEAD_BEEF});
        d_q.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0});
        drain("drain_st_ld");
        chk("load_after_store", 64'(d_rdata), 64'hDEAD_BEEF);

        // Simultaneous requests.
        if_q.push_back('{we: 1'b0, addr: 32'h8, wdata: 32'h0});
        d_q.push_back('{we: 1'b0, addr: 32'h10, wdata: 32'h0});
        drain("drain_tie");

        // Lone fetch leaves IF as last grant, then both ports request continuously.
        if_q.push_back('{we: 1'b0, addr: 32'h20, wdata: 32'h0});
        drain("drain_pre_cont");
        for (int i = 0; i < 4; i++) begin
            if_q.push_back('{we: 1'b0, addr: 32'h100 + 32'(4 * i), wdata: 32'h0});
            d_q.push_back('{we: 1'b0, addr: 32'h200 + 32'(4 * i), wdata: 32'h0});
        end
        drain("drain_cont");

        // Reset during the wait phase of a load; the held request is re-served.
        d_q.push_back('{we: 1'b0, addr: 32'h24, wdata: 32'h0});
        for (int n = 0; n < 50; n++) begin
            if (busy && cyc == m_issue + 1) break;
            cycle();
        end
        chk("reached_wait", 64'(busy && cyc == m_issue + 1), 64'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        drain("drain_rst_wait");
        chk("reserved_load", 64'(d_rdata), 64'(ref_mem[9]));

        // Back-to-back fetches, address changing on the done edge.
        if_q.push_back('{we: 1'b0, addr: 32'h0, wdata: 32'h0});
        if_q.push_back('{we: 1'b0, addr: 32'h4, wdata: 32'h0});
        drain("drain_b2b");
        chk("fetch4_word", 64'(if_rdata), 64'(init_word(1)));

        // Random traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 3) == 0 && if_q.size() < 2)
                if_q.push_back('{we: 1'b0, addr: raddr(), wdata: 32'h0});
            if ($urandom_range(0, 3) == 0 && d_q.size() < 2)
                d_q.push_back('{we: 1'($urandom_range(0, 1)), addr: raddr(), wdata: $urandom});
            reset = ($urandom_range(0, 299) == 0);
            cycle();
        end
        reset = 1'b0;
        drain("drain_random");

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
